// File: rtl/ebtb_pkg.sv
// Shared constants and 8b/10b sub-block coding functions for the wide encoder.
package ebtb_pkg;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic       RD_NEG = 1'b0;
  localparam logic       RD_POS = 1'b1;

  // Returns {abcdei, neutral}; the table holds the RD- column, RD+ is its complement.
  function automatic logic [6:0] enc_5b6b(input logic [4:0] x, input logic k, input logic rd);
    logic [5:0] c;
    logic       neutral;
    c = 6'b000000;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      5'd31: c = 6'b101011;
      default: c = 6'b000000;
    endcase
    if (k && (x == 5'd28)) c = 6'b001111;
    neutral = ($countones(c) == 3);
    // D.7 is balanced but still alternates with disparity
    if ((rd == RD_POS) && (!neutral || (x == 5'd7))) c = ~c;
    return {c, neutral};
  endfunction

  // Returns {fghj, neutral}; rd is the disparity after the 6b sub-block.
  function automatic logic [4:0] enc_3b4b(input logic [2:0] y, input logic k, input logic rd,
                                          input logic [4:0] x);
    logic [3:0] c;
    logic       neutral;
    logic       alt;
    c   = 4'b0000;
    alt = ((rd == RD_NEG) && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
          ((rd == RD_POS) && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    if (k) begin
      case (y)
        3'd0: c = 4'b1011;
        3'd1: c = 4'b0110;
        3'd2: c = 4'b1010;
        3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;
        3'd5: c = 4'b0101;
        3'd6: c = 4'b1001;
        3'd7: c = 4'b0111;
        default: c = 4'b0000;
      endcase
    end else begin
      case (y)
        3'd0: c = 4'b1011;
        3'd1: c = 4'b1001;
        3'd2: c = 4'b0101;
        3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;
        3'd5: c = 4'b1010;
        3'd6: c = 4'b0110;
        3'd7: c = alt ? 4'b0111 : 4'b1110;
        default: c = 4'b0000;
      endcase
    end
    neutral = ($countones(c) == 2);
    // every K column entry alternates; D.x.3 alternates although balanced
    if ((rd == RD_POS) && (k || !neutral || (y == 3'd3))) c = ~c;
    return {c, neutral};
  endfunction

  function automatic logic k_valid(input logic [7:0] b);
    logic [4:0] x;
    x = b[4:0];
    return (x == 5'd28) ||
           ((b[7:5] == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

endpackage

// File: rtl/ebtb_lane.sv
// One combinational 8b/10b lane: invalid K substitution, 6b then 4b coding, disparity out.
module ebtb_lane
  import ebtb_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_k,
  input  logic       i_rd,
  output logic [9:0] o_code,
  output logic       o_rd,
  output logic       o_k_err
);

  logic       w_k_err;
  logic [7:0] w_byte;
  logic [6:0] w_6b;
  logic [4:0] w_4b;
  logic       w_rd_mid;

  assign w_k_err  = i_k && !k_valid(i_byte);
  assign w_byte   = w_k_err ? K28_5 : i_byte;
  assign w_6b     = enc_5b6b(w_byte[4:0], i_k, i_rd);
  assign w_rd_mid = w_6b[0] ? i_rd : ~i_rd;
  assign w_4b     = enc_3b4b(w_byte[7:5], i_k, w_rd_mid, w_byte[4:0]);
  assign o_rd     = w_4b[0] ? w_rd_mid : ~w_rd_mid;
  assign o_code   = {w_6b[6:1], w_4b[4:1]};
  assign o_k_err  = w_k_err;

endmodule

// File: rtl/ebtb_wide.sv
// Multi-byte 8b/10b encoder: chained lanes, running-disparity register, valid/ready output stage.
module ebtb_wide
  import ebtb_pkg::*;
#(
  parameter int unsigned BYTES           = 2,
  parameter bit          IDLE_EN_DEFAULT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*BYTES-1:0]    in_data,
  input  logic [BYTES-1:0]      in_k,
  input  logic                  idle_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*BYTES-1:0]   out_data,
  output logic                  out_idle,
  output logic                  out_rd,
  output logic [BYTES-1:0]      k_err
);

  localparam int unsigned DW = 8 * BYTES;
  localparam int unsigned CW = 10 * BYTES;

  logic          w_load;
  logic [DW-1:0] w_lane_data;
  logic [BYTES-1:0] w_lane_k;
  logic [BYTES:0]   w_rd_chain;
  logic [CW-1:0]    w_code;
  logic [BYTES-1:0] w_k_err;

  logic             r_rd;
  logic             r_idle_en;
  logic             r_valid;
  logic             r_idle;
  logic [CW-1:0]    r_data;
  logic [BYTES-1:0] r_k_err;

  assign w_load   = !r_valid || out_ready;
  assign in_ready = w_load;

  // With no input word the lanes see K28.5 everywhere, which is the idle pattern
  assign w_lane_data   = in_valid ? in_data : {BYTES{K28_5}};
  assign w_lane_k      = in_valid ? in_k : {BYTES{1'b1}};
  assign w_rd_chain[0] = r_rd;

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    ebtb_lane u_lane (
      .i_byte  (w_lane_data[8*g +: 8]),
      .i_k     (w_lane_k[g]),
      .i_rd    (w_rd_chain[g]),
      .o_code  (w_code[10*g +: 10]),
      .o_rd    (w_rd_chain[g+1]),
      .o_k_err (w_k_err[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd      <= RD_NEG;
      r_idle_en <= IDLE_EN_DEFAULT;
      r_valid   <= 1'b0;
      r_idle    <= 1'b0;
      r_data    <= '0;
      r_k_err   <= '0;
    end else begin
      r_idle_en <= idle_en;
      if (w_load) begin
        if (in_valid || r_idle_en) begin
          r_valid <= 1'b1;
          r_idle  <= !in_valid;
          r_data  <= w_code;
          r_k_err <= in_valid ? w_k_err : '0;
          r_rd    <= w_rd_chain[BYTES];
        end else begin
          r_valid <= 1'b0;
          r_idle  <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_idle  = r_idle;
  assign out_data  = r_data;
  assign out_rd    = r_rd;
  assign k_err     = r_k_err;

endmodule

// File: tb/tb_ebtb_wide.sv
// Self-checking bench for ebtb_wide (BYTES=2): vector table, scoreboard with backpressure, idle/reset sequences.
`timescale 1ns/1ps
module tb_ebtb_wide;

  localparam int unsigned BYTES = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [8*BYTES-1:0]  in_data;
  logic [BYTES-1:0]    in_k;
  logic                idle_en;
  logic                out_valid;
  logic                out_ready;
  logic [10*BYTES-1:0] out_data;
  logic                out_idle;
  logic                out_rd;
  logic [BYTES-1:0]    k_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  k;
    logic [19:0] code;
    logic        rd;
    logic [1:0]  kerr;
  } vec_t;

  typedef struct {
    logic [19:0] code;
    logic        rd;
    logic        idle;
    logic [1:0]  kerr;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  logic m_rd;
  logic m_ien;

  always #5 clk = ~clk;

  ebtb_wide #(.BYTES(BYTES), .IDLE_EN_DEFAULT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .idle_en   (idle_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idle  (out_idle),
    .out_rd    (out_rd),
    .k_err     (k_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference tables written as {RD- column, RD+ column}
  function automatic logic [5:0] m6(input logic [4:0] x, input logic k, input logic rd);
    logic [11:0] t;
    case (x)
      5'd0:  t = 12'b100111_011000;  5'd1:  t = 12'b011101_100010;
      5'd2:  t = 12'b101101_010010;  5'd3:  t = 12'b110001_110001;
      5'd4:  t = 12'b110101_001010;  5'd5:  t = 12'b101001_101001;
      5'd6:  t = 12'b011001_011001;  5'd7:  t = 12'b111000_000111;
      5'd8:  t = 12'b111001_000110;  5'd9:  t = 12'b100101_100101;
      5'd10: t = 12'b010101_010101;  5'd11: t = 12'b110100_110100;
      5'd12: t = 12'b001101_001101;  5'd13: t = 12'b101100_101100;
      5'd14: t = 12'b011100_011100;  5'd15: t = 12'b010111_101000;
      5'd16: t = 12'b011011_100100;  5'd17: t = 12'b100011_100011;
      5'd18: t = 12'b010011_010011;  5'd19: t = 12'b110010_110010;
      5'd20: t = 12'b001011_001011;  5'd21: t = 12'b101010_101010;
      5'd22: t = 12'b011010_011010;  5'd23: t = 12'b111010_000101;
      5'd24: t = 12'b110011_001100;  5'd25: t = 12'b100110_100110;
      5'd26: t = 12'b010110_010110;  5'd27: t = 12'b110110_001001;
      5'd28: t = 12'b001110_001110;  5'd29: t = 12'b101110_010001;
      5'd30: t = 12'b011110_100001;  default: t = 12'b101011_010100;
    endcase
    if (k && x == 5'd28) t = 12'b001111_110000;
    return rd ? t[5:0] : t[11:6];
  endfunction

  function automatic logic [3:0] m4(input logic [2:0] y, input logic k, input logic rd,
                                    input logic [4:0] x);
    logic [7:0] t;
    logic       a7;
    a7 = (!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
         ( rd && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    if (k) begin
      case (y)
        3'd0: t = 8'b1011_0100;  3'd1: t = 8'b0110_1001;
        3'd2: t = 8'b1010_0101;  3'd3: t = 8'b1100_0011;
        3'd4: t = 8'b1101_0010;  3'd5: t = 8'b0101_1010;
        3'd6: t = 8'b1001_0110;  default: t = 8'b0111_1000;
      endcase
    end else begin
      case (y)
        3'd0: t = 8'b1011_0100;  3'd1: t = 8'b1001_1001;
        3'd2: t = 8'b0101_0101;  3'd3: t = 8'b1100_0011;
        3'd4: t = 8'b1101_0010;  3'd5: t = 8'b1010_1010;
        3'd6: t = 8'b0110_0110;  default: t = a7 ? 8'b0111_1000 : 8'b1110_0001;
      endcase
    end
    return rd ? t[3:0] : t[7:4];
  endfunction

  function automatic logic next_rd(input logic rd, input int ones, input int half);
    if (ones > half) return 1'b1;
    if (ones < half) return 1'b0;
    return rd;
  endfunction

  task automatic model_word(input logic [15:0] d, input logic [1:0] k, inout logic rd,
                            output logic [19:0] code, output logic [1:0] kerr);
    logic [7:0] b;
    logic [5:0] c6;
    logic [3:0] c4;
    for (int l = 0; l < 2; l++) begin
      b = d[8*l +: 8];
      kerr[l] = 1'b0;
      if (k[l] && !(b[4:0] == 5'd28 || b == 8'hF7 || b == 8'hFB || b == 8'hFD || b == 8'hFE)) begin
        b = 8'hBC;
        kerr[l] = 1'b1;
      end
      c6 = m6(b[4:0], k[l], rd);
      rd = next_rd(rd, $countones(c6), 3);
      c4 = m4(b[7:5], k[l], rd, b[4:0]);
      rd = next_rd(rd, $countones(c4), 2);
      code[10*l +: 10] = {c6, c4};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scoreboard cycle: entered 1ns after an edge with inputs already driven
  task automatic cycle();
    exp_t        e;
    logic [19:0] c;
    logic [1:0]  ke;
    logic        r;
    #3;
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: word %0h presented, none expected", out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.code));
        chk("sb_rd",   32'(out_rd),   32'(e.rd));
        chk("sb_idle", 32'(out_idle), 32'(e.idle));
        chk("sb_kerr", 32'(k_err),    32'(e.kerr));
      end
    end
    if (in_ready && (in_valid || m_ien)) begin
      r = m_rd;
      if (in_valid) model_word(in_data, in_k, r, c, ke);
      else begin
        model_word(16'hBCBC, 2'b11, r, c, ke);
        ke = 2'b00;
      end
      m_rd = r;
      sb.push_back('{code: c, rd: r, idle: !in_valid, kerr: ke});
    end
    @(posedge clk);
    m_ien = idle_en;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0] snap_data;
    logic        snap_rd;

    vecs[0] = '{16'hBCBC, 2'b11, 20'b1100000101_0011111010, 1'b0, 2'b00};
    vecs[1] = '{16'hF100, 2'b00, 20'b1000110111_1001110100, 1'b1, 2'b00};
    vecs[2] = '{16'hBC00, 2'b11, 20'b0011111010_1100000101, 1'b1, 2'b01};
    vecs[3] = '{16'hF100, 2'b00, 20'b1000110001_0110001011, 1'b0, 2'b00};
    vecs[4] = '{16'hEBEB, 2'b00, 20'b1101001000_1101001110, 1'b0, 2'b00};
    vecs[5] = '{16'hFCF7, 2'b11, 20'b0011111000_1110101000, 1'b0, 2'b00};
    vecs[6] = '{16'h6763, 2'b00, 20'b1110001100_1100011100, 1'b0, 2'b00};
    vecs[7] = '{16'hF1B5, 2'b10, 20'b0011111010_1010101010, 1'b1, 2'b10};
    vecs[8] = '{16'hF4F4, 2'b00, 20'b0010110111_0010110001, 1'b1, 2'b00};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_k = '0; idle_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_data",  32'(out_data),  32'(0));
    chk("rst_idle",  32'(out_idle),  32'(1'b0));
    chk("rst_rd",    32'(out_rd),    32'(1'b0));
    chk("rst_kerr",  32'(k_err),     32'(0));

    // Vector table, one word per cycle from RD-
    in_valid = 1'b1; in_data = vecs[0].data; in_k = vecs[0].k;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = vecs[i].data;
      in_k    = vecs[i].k;
      step();
      chk($sformatf("vec%0d_data", i), 32'(out_data),  32'(vecs[i].code));
      chk($sformatf("vec%0d_rd", i),   32'(out_rd),    32'(vecs[i].rd));
      chk($sformatf("vec%0d_kerr", i), 32'(k_err),     32'(vecs[i].kerr));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(1'b1));
      chk($sformatf("vec%0d_idle", i), 32'(out_idle),  32'(1'b0));
    end
    in_valid = 1'b0;
    step();
    chk("empty_valid", 32'(out_valid), 32'(1'b0));
    chk("empty_hold",  32'(out_data),  32'(vecs[8].code));

    // Backpressure: one word accepted, then stalled for 5 cycles
    m_rd = vecs[8].rd;
    m_ien = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_k = 2'b00;
    cycle();
    snap_data = out_data;
    snap_rd   = out_rd;
    in_data   = 16'hA55A;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'(1'b0));
      chk("stall_data",     32'(out_data), 32'(snap_data));
      chk("stall_rd",       32'(out_rd),   32'(snap_rd));
      cycle();
    end

    // Random traffic with random backpressure and idle insertion
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_k      = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      if ($urandom_range(0, 9) == 0) in_data[7:0] = 8'hBC;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) idle_en = ~idle_en;
      cycle();
    end
    in_valid = 1'b0; idle_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    // Idle stream straight out of reset (internal idle-enable resets to 1)
    #1 reset = 1'b0;
    idle_en = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_data",  32'(out_data),  32'(20'b1100000101_0011111010));
      chk("idle_flag",  32'(out_idle),  32'(1'b1));
      chk("idle_rd",    32'(out_rd),    32'(1'b0));
      chk("idle_kerr",  32'(k_err),     32'(0));
      chk("idle_valid", 32'(out_valid), 32'(1'b1));
    end

    // Real data wins over idle
    in_valid = 1'b1; in_data = 16'hF100; in_k = 2'b00;
    step();
    chk("win_data", 32'(out_data), 32'(20'b1000110111_1001110100));
    chk("win_idle", 32'(out_idle), 32'(1'b0));
    chk("win_rd",   32'(out_rd),   32'(1'b1));

    // Stall with another word pending, then asynchronous reset mid-cycle
    out_ready = 1'b0; in_data = 16'h0000;
    step();
    chk("hold_data", 32'(out_data), 32'(20'b1000110111_1001110100));
    chk("hold_rd",   32'(out_rd),   32'(1'b1));
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'(1'b0));
    chk("arst_data",  32'(out_data),  32'(0));
    chk("arst_idle",  32'(out_idle),  32'(1'b0));
    chk("arst_rd",    32'(out_rd),    32'(1'b0));
    chk("arst_kerr",  32'(k_err),     32'(0));
    @(negedge clk);
    idle_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0000;
    reset = 1'b1;
    step();
    chk("post_rst_data",  32'(out_data),  32'(20'b1001110100_1001110100));
    chk("post_rst_rd",    32'(out_rd),    32'(1'b0));
    chk("post_rst_valid", 32'(out_valid), 32'(1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
